// File: rtl/debug_monmem_pkg.sv
// Shared field positions, FSM encodings and command types for the debug monitor memory.
package debug_monmem_pkg;

  localparam int JDO_ADDR_LSB   = 2;
  localparam int JDO_ADDR_MSB   = 33;
  localparam int JDO_RD_BIT     = 34;
  localparam int JDO_CLRERR_BIT = 35;

  // One-hot FSM encodings
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_J_RD  = 4'b0010;
  localparam logic [3:0] ST_J_CAP = 4'b0100;
  localparam logic [3:0] ST_J_WR  = 4'b1000;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_STREAM,
    CMD_WRITE
  } cmd_e;

  // True when a jdo word address does not fit in an aw-bit RAM address
  function automatic logic addr_out_of_range(input logic [31:0] word_addr, input int aw);
    return |(word_addr >> aw);
  endfunction

endpackage

// File: rtl/niosiisystem_nios2_gen2_0_cpu_debug_monmem_ram.sv
// Single-port DEPTH x 32 monitor RAM with byte enables and a registered read port.
module niosiisystem_nios2_gen2_0_cpu_debug_monmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [DEPTH];
  logic [31:0] q_q, q_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read samples the array before this edge's write lands: same-address returns old data
  always_comb begin
    q_d = q_q;
    if (re) q_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/niosiisystem_nios2_gen2_0_cpu_debug_monmem.sv
// JTAG debug monitor memory: decodes ocimem strobes into monitor RAM accesses and
// shares the RAM with a CPU Avalon-MM slave, JTAG taking priority.
module niosiisystem_nios2_gen2_0_cpu_debug_monmem
  import debug_monmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  logic [3:0]    state_q, state_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          pend_vld_q, pend_vld_d;
  cmd_e          pend_cmd_q, pend_cmd_d;
  logic [35:0]   pend_jdo_q, pend_jdo_d;

  cmd_e          strobe_cmd, exec_cmd;
  logic [35:0]   exec_jdo;
  logic          strobe_any, strobe_multi, idle;
  logic          err_set, err_clr;
  logic          cpu_rd, cpu_wr;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata, ram_q;
  logic          unused_jdo;

  assign unused_jdo = ^jdo[37:36];

  always_comb begin
    strobe_cmd = CMD_NONE;
    if (take_action_ocimem_b)         strobe_cmd = CMD_WRITE;
    else if (take_action_ocimem_a)    strobe_cmd = CMD_LOAD;
    else if (take_no_action_ocimem_a) strobe_cmd = CMD_STREAM;
  end

  assign strobe_any   = (strobe_cmd != CMD_NONE);
  assign strobe_multi = (take_action_ocimem_b & take_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a) |
                        (take_action_ocimem_a & take_no_action_ocimem_a);
  assign idle            = (state_q == ST_IDLE);
  assign avs_waitrequest = !idle | strobe_any | pend_vld_q;
  assign cpu_rd          = avs_read  & !avs_waitrequest;
  assign cpu_wr          = avs_write & !avs_waitrequest;

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    ready_d    = ready_q;
    wdata_d    = wdata_q;
    pend_vld_d = pend_vld_q;
    pend_cmd_d = pend_cmd_q;
    pend_jdo_d = pend_jdo_q;
    exec_cmd   = CMD_NONE;
    exec_jdo   = jdo[35:0];
    err_set    = strobe_multi;
    err_clr    = 1'b0;

    // A pending command runs first; a strobe arriving alongside it takes the freed slot
    if (idle) begin
      if (pend_vld_q) begin
        exec_cmd   = pend_cmd_q;
        exec_jdo   = pend_jdo_q;
        pend_vld_d = strobe_any;
        pend_cmd_d = strobe_cmd;
        pend_jdo_d = jdo[35:0];
      end else begin
        exec_cmd = strobe_cmd;
      end
    end else if (strobe_any) begin
      if (pend_vld_q) begin
        err_set = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_cmd_d = strobe_cmd;
        pend_jdo_d = jdo[35:0];
      end
    end

    case (exec_cmd)
      CMD_LOAD: begin
        if (addr_out_of_range(exec_jdo[JDO_ADDR_MSB:JDO_ADDR_LSB], AW)) begin
          err_set = 1'b1;
          ready_d = 1'b1;
        end else begin
          mon_a_d = exec_jdo[AW+1:JDO_ADDR_LSB];
          err_clr = exec_jdo[JDO_CLRERR_BIT];
          if (exec_jdo[JDO_RD_BIT]) begin
            state_d = ST_J_RD;
            ready_d = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end
      end
      CMD_STREAM: begin
        mon_a_d = mon_a_q + AW'(1);
        state_d = ST_J_RD;
        ready_d = 1'b0;
      end
      CMD_WRITE: begin
        wdata_d = exec_jdo[31:0];
        state_d = ST_J_WR;
        ready_d = 1'b0;
      end
      default: ;
    endcase

    case (state_q)
      ST_J_RD:  state_d = ST_J_CAP;
      ST_J_CAP: begin
        mon_d_d = ram_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_J_WR: begin
        mon_a_d = mon_a_q + AW'(1);
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    error_d = err_set ? 1'b1 : (err_clr ? 1'b0 : error_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
      wdata_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= CMD_NONE;
      pend_jdo_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      wdata_q    <= wdata_d;
      pend_vld_q <= pend_vld_d;
      pend_cmd_q <= pend_cmd_d;
      pend_jdo_q <= pend_jdo_d;
    end
  end

  // Writes are gated by reset so an aborted operation never lands in the RAM
  assign ram_we    = !reset & ((state_q == ST_J_WR) | cpu_wr);
  assign ram_re    = (state_q == ST_J_RD) | cpu_rd;
  assign ram_addr  = ((state_q == ST_J_RD) || (state_q == ST_J_WR)) ? mon_a_q : avs_address;
  assign ram_be    = (state_q == ST_J_WR) ? 4'hF : avs_byteenable;
  assign ram_wdata = (state_q == ST_J_WR) ? wdata_q : avs_writedata;

  niosiisystem_nios2_gen2_0_cpu_debug_monmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .addr  (ram_addr),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign avs_readdata  = ram_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_niosiisystem_nios2_gen2_0_cpu_debug_monmem.sv
// Scoreboard bench for the debug monitor memory: JTAG and CPU expectations are queued
// at stimulus time and compared when the DUT completes each operation.
module tb_niosiisystem_nios2_gen2_0_cpu_debug_monmem;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [31:0]   MonDReg;
  logic          monitor_ready;
  logic          monitor_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [DEPTH];
  logic [7:0]  mona_m = 8'd0;
  logic [31:0] mond_m = 32'd0;
  logic [31:0] jtag_exp [$];
  logic [31:0] cpu_exp  [$];
  logic        ready_prev = 1'b1;

  niosiisystem_nios2_gen2_0_cpu_debug_monmem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // JTAG completion monitor: each rising edge of monitor_ready retires one queued op
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (ready_prev === 1'b0 && monitor_ready === 1'b1) begin
      checks++;
      if (jtag_exp.size() == 0) begin
        errors++;
        $display("FAIL jtag_unexpected_done MonDReg=%h", MonDReg);
      end else begin
        e = jtag_exp.pop_front();
        if (MonDReg !== e) begin
          errors++;
          $display("FAIL jtag_mondreg got=%h exp=%h", MonDReg, e);
        end
      end
    end
    ready_prev = monitor_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [31:0] waddr, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[33:2] = waddr;
    j[34] = rd;
    j[35] = clr;
    if (waddr < DEPTH) begin
      mona_m = waddr[7:0];
      if (rd) begin
        mond_m = ram_m[mona_m];
        jtag_exp.push_back(mond_m);
      end
    end
    jdo = j;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_na();
    mona_m = mona_m + 8'd1;
    mond_m = ram_m[mona_m];
    jtag_exp.push_back(mond_m);
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jtag_exp.push_back(mond_m);
    ram_m[mona_m] = d;
    mona_m = mona_m + 8'd1;
    jdo = {6'b0, d};
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (monitor_ready === 1'b1 && avs_waitrequest === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle_timeout ready=%b waitreq=%b", name, monitor_ready, avs_waitrequest);
    end
  endtask

  task automatic cpu_read(input logic [7:0] a);
    logic [31:0] e;
    bit acc;
    cpu_exp.push_back(ram_m[a]);
    avs_address = a;
    avs_read = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = !avs_waitrequest;
      tick();
    end
    avs_read = 1'b0;
    e = cpu_exp.pop_front();
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cpu_read_timeout addr=%0d", a);
    end else if (avs_readdata !== e) begin
      errors++;
      $display("FAIL cpu_read addr=%0d got=%h exp=%h", a, avs_readdata, e);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bit acc;
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = !avs_waitrequest;
      tick();
    end
    avs_write = 1'b0;
    for (int i = 0; i < 4; i++) if (be[i]) ram_m[a][8*i +: 8] = d[8*i +: 8];
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cpu_write_timeout addr=%0d", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 5;
    if (MonDReg !== 32'd0) begin errors++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", monitor_ready); end
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    if (avs_readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
    if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got=%b exp=0", avs_waitrequest); end
  endtask

  task automatic test_jtag_write();
    jtag_b(32'hDEADBEEF);
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_low got=%b exp=0", monitor_ready); end
    tick();
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_high got=%b exp=1", monitor_ready); end
    jtag_b(32'h0BADF00D);
    wait_idle("wr2");
    cpu_read(8'd0);
    cpu_read(8'd1);
  endtask

  task automatic test_jtag_read();
    cpu_write(8'd5, 32'h12345678, 4'hF);
    jtag_a(32'd5, 1'b1, 1'b0);
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_c1 got=%b exp=0", monitor_ready); end
    tick();
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_c2 got=%b exp=0", monitor_ready); end
    tick();
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_c3 got=%b exp=1", monitor_ready); end
  endtask

  task automatic test_wrap();
    cpu_write(8'd255, 32'h55AA00FF, 4'hF);
    jtag_a(32'd255, 1'b1, 1'b0);
    wait_idle("wrap_load");
    jtag_na();
    wait_idle("wrap_na1");
    jtag_na();
    wait_idle("wrap_na2");
  endtask

  task automatic test_out_of_range();
    jtag_a(32'h400, 1'b1, 1'b0);
    checks += 2;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL oor_error got=%b exp=1", monitor_error); end
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL oor_ready got=%b exp=1", monitor_ready); end
    tick();
    tick();
    checks++;
    if (MonDReg !== mond_m) begin errors++; $display("FAIL oor_mondreg got=%h exp=%h", MonDReg, mond_m); end
    jtag_a(32'd3, 1'b0, 1'b1);
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL clrerr got=%b exp=0", monitor_error); end
  endtask

  task automatic test_back_to_back();
    jtag_a(32'd5, 1'b1, 1'b0);
    jtag_b(32'h33334444);
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    wait_idle("b2b");
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL b2b_drop_error got=%b exp=1", monitor_error); end
    jtag_b(32'h77778888);
    wait_idle("b2b_post");
    cpu_read(8'd5);
    cpu_read(8'd6);
    jtag_a(32'd0, 1'b0, 1'b1);
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL b2b_clrerr got=%b exp=0", monitor_error); end
  endtask

  task automatic test_cpu_vs_jtag();
    int waited;
    bit acc;
    jdo = '0;
    jdo[33:2] = 32'd5;
    jdo[34] = 1'b1;
    mona_m = 8'd5;
    mond_m = ram_m[5];
    jtag_exp.push_back(mond_m);
    take_action_ocimem_a = 1'b1;
    avs_address = 8'd5;
    avs_writedata = 32'hAABBCCDD;
    avs_byteenable = 4'b0011;
    avs_write = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL col_waitreq_c0 got=%b exp=1", avs_waitrequest); end
    tick();
    take_action_ocimem_a = 1'b0;
    waited = 0;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = !avs_waitrequest;
      tick();
      if (!acc) waited++;
    end
    avs_write = 1'b0;
    ram_m[5][15:0] = 16'hCCDD;
    checks++;
    if (!acc || waited != 2) begin
      errors++;
      $display("FAIL col_stall_cycles got=%0d exp=2 accepted=%b", waited, acc);
    end
    cpu_read(8'd5);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = 4'hF;
    for (int i = 0; i < DEPTH; i++) ram_m[i] = 32'd0;

    test_reset();
    test_jtag_write();
    test_jtag_read();
    test_wrap();
    test_out_of_range();
    test_back_to_back();
    test_cpu_vs_jtag();
    tick();
    tick();

    checks++;
    if (jtag_exp.size() != 0) begin
      errors++;
      $display("FAIL jtag_queue_leftover got=%0d exp=0", jtag_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
